// File: rtl/hi_lo_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and
// restoring shift-subtract divide behind a start/busy/done handshake.
module hi_lo_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       operation,
  input  logic [WIDTH-1:0] input_1,
  input  logic [WIDTH-1:0] input_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] acc;
  logic [WIDTH-1:0] operand_b;
  logic             op_div;
  logic             neg_main;
  logic             neg_rem;
  logic             div_zero;

  logic             is_mul_c;
  logic             is_div_c;
  logic             is_signed_c;
  logic             sign_1_c;
  logic             sign_2_c;
  logic [WIDTH-1:0] mag_1_c;
  logic [WIDTH-1:0] mag_2_c;

  logic             load_c;
  logic             iter_c;
  logic             fix_c;
  logic             mthi_c;
  logic             mtlo_c;

  logic [WIDTH:0]   add_sum_c;
  logic [WIDTH:0]   rem_shift_c;
  logic [WIDTH-1:0] sub_diff_c;
  logic [ACC_W-1:0] acc_step_c;
  logic [ACC_W-1:0] prod_c;
  logic [WIDTH-1:0] quot_c;
  logic [WIDTH-1:0] rem_c;

  // Opcode decode and operand magnitudes for the signed forms
  always_comb begin
    is_mul_c    = (operation == OP_MULT) || (operation == OP_MULTU);
    is_div_c    = (operation == OP_DIV)  || (operation == OP_DIVU);
    is_signed_c = (operation == OP_MULT) || (operation == OP_DIV);
    sign_1_c    = is_signed_c && input_1[WIDTH-1];
    sign_2_c    = is_signed_c && input_2[WIDTH-1];
    mag_1_c     = sign_1_c ? (~input_1 + WIDTH'(1)) : input_1;
    mag_2_c     = sign_2_c ? (~input_2 + WIDTH'(1)) : input_2;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && (is_mul_c || is_div_c)) state_next = CALC;
      CALC:    if (count == LAST_ITER) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_c = 1'b0;
    iter_c = 1'b0;
    fix_c  = 1'b0;
    mthi_c = 1'b0;
    mtlo_c = 1'b0;
    case (state)
      IDLE: begin
        load_c = start && (is_mul_c || is_div_c);
        mthi_c = start && (operation == OP_MTHI);
        mtlo_c = start && (operation == OP_MTLO);
      end
      CALC:    iter_c = 1'b1;
      FIX:     fix_c  = 1'b1;
      default: ;
    endcase
  end

  // One radix-2 step; acc holds {partial product | multiplier} or {remainder | quotient}
  always_comb begin
    add_sum_c   = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, operand_b} : '0);
    rem_shift_c = acc[ACC_W-1:WIDTH-1];
    sub_diff_c  = rem_shift_c[WIDTH-1:0] - operand_b;
    if (op_div) begin
      if (rem_shift_c >= {1'b0, operand_b})
        acc_step_c = {sub_diff_c, acc[WIDTH-2:0], 1'b1};
      else
        acc_step_c = {rem_shift_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_step_c = {add_sum_c, acc[WIDTH-1:1]};
    end
  end

  // Sign restoration applied on the way into HI/LO
  always_comb begin
    prod_c = neg_main ? (~acc + ACC_W'(1)) : acc;
    quot_c = neg_main ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
    rem_c  = neg_rem  ? (~acc[ACC_W-1:WIDTH] + WIDTH'(1)) : acc[ACC_W-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      acc       <= '0;
      operand_b <= '0;
      op_div    <= 1'b0;
      neg_main  <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= fix_c;
      if (load_c) begin
        count    <= '0;
        op_div   <= is_div_c;
        neg_main <= sign_1_c ^ sign_2_c;
        neg_rem  <= sign_1_c;
        div_zero <= (input_2 == '0);
        if (is_div_c) begin
          acc       <= {{WIDTH{1'b0}}, mag_1_c};
          operand_b <= mag_2_c;
        end else begin
          acc       <= {{WIDTH{1'b0}}, mag_2_c};
          operand_b <= mag_1_c;
        end
      end
      if (iter_c) begin
        acc   <= acc_step_c;
        count <= count + CNT_W'(1);
      end
      // Zero divisor leaves the dividend in the remainder, so only LO needs forcing
      if (fix_c) begin
        if (op_div) begin
          lo <= div_zero ? {WIDTH{1'b1}} : quot_c;
          hi <= rem_c;
        end else begin
          hi <= prod_c[ACC_W-1:WIDTH];
          lo <= prod_c[WIDTH-1:0];
        end
      end
      if (mthi_c) hi <= input_1;
      if (mtlo_c) lo <= input_1;
    end
  end

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Bench for hi_lo_muldiv_unit: directed WIDTH=32 cases plus a WIDTH=8 instance
// checked every cycle against an arithmetic reference with fixed latency.
module tb_hi_lo_muldiv_unit;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_v [2];
  logic [5:0]  op_v    [2];
  logic [31:0] a_v     [2];
  logic [31:0] b_v     [2];

  logic        busy32, done32, busy8, done8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;
  logic        o_busy [2];
  logic        o_done [2];
  logic [31:0] o_hi   [2];
  logic [31:0] o_lo   [2];

  assign o_busy[0] = busy32;
  assign o_done[0] = done32;
  assign o_hi[0]   = hi32;
  assign o_lo[0]   = lo32;
  assign o_busy[1] = busy8;
  assign o_done[1] = done8;
  assign o_hi[1]   = {24'h0, hi8};
  assign o_lo[1]   = {24'h0, lo8};

  hi_lo_muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start_v[0]), .operation(op_v[0]),
    .input_1(a_v[0]), .input_2(b_v[0]),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  hi_lo_muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start_v[1]), .operation(op_v[1]),
    .input_1(a_v[1][7:0]), .input_2(b_v[1][7:0]),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  int total = 0;
  int bad   = 0;
  logic check_en = 1'b0;

  function automatic int width_of(input int d);
    return (d == 0) ? 32 : 8;
  endfunction

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference HI/LO for one arithmetic op at width w, from plain integer arithmetic
  function automatic void ref_result(input int w, input logic [5:0] op,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] rhi, output logic [31:0] rlo);
    longint unsigned mask, ua, ub, up;
    longint sa, sb, sp, smask, most_neg;
    mask     = (64'd1 << w) - 64'd1;
    smask    = longint'(mask);
    ua       = 64'(a) & mask;
    ub       = 64'(b) & mask;
    sa       = a[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb       = b[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    most_neg = -(longint'(1) << (w - 1));
    rhi = '0;
    rlo = '0;
    case (op)
      OP_MULT: begin
        sp  = sa * sb;
        rhi = 32'((sp >>> w) & smask);
        rlo = 32'(sp & smask);
      end
      OP_MULTU: begin
        up  = ua * ub;
        rhi = 32'((up >> w) & mask);
        rlo = 32'(up & mask);
      end
      OP_DIV: begin
        if (sb == 0) begin
          rlo = 32'(mask);
          rhi = 32'(ua);
        end else if (sa == most_neg && sb == -1) begin
          rlo = 32'(longint'(1) << (w - 1));
          rhi = '0;
        end else begin
          rlo = 32'((sa / sb) & smask);
          rhi = 32'((sa % sb) & smask);
        end
      end
      OP_DIVU: begin
        if (ub == 0) begin
          rlo = 32'(mask);
          rhi = 32'(ua);
        end else begin
          rlo = 32'(ua / ub);
          rhi = 32'(ua % ub);
        end
      end
      default: ;
    endcase
  endfunction

  // Model: result appears WIDTH+1 edges after acceptance, busy in between
  int unsigned m_left [2];
  logic        m_busy [2];
  logic        m_done [2];
  logic [31:0] m_hi   [2];
  logic [31:0] m_lo   [2];
  logic [31:0] p_hi   [2];
  logic [31:0] p_lo   [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_left[d] = 0;
        m_busy[d] = 1'b0;
        m_done[d] = 1'b0;
        m_hi[d]   = '0;
        m_lo[d]   = '0;
      end else begin
        m_done[d] = 1'b0;
        if (m_left[d] != 0) begin
          m_left[d]--;
          if (m_left[d] == 0) begin
            m_hi[d]   = p_hi[d];
            m_lo[d]   = p_lo[d];
            m_busy[d] = 1'b0;
            m_done[d] = 1'b1;
          end
        end else if (start_v[d]) begin
          case (op_v[d])
            OP_MTHI: m_hi[d] = a_v[d] & 32'((64'd1 << width_of(d)) - 64'd1);
            OP_MTLO: m_lo[d] = a_v[d] & 32'((64'd1 << width_of(d)) - 64'd1);
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              ref_result(width_of(d), op_v[d], a_v[d], b_v[d], p_hi[d], p_lo[d]);
              m_left[d] = width_of(d) + 1;
              m_busy[d] = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int d = 0; d < 2; d++) begin
        cmp($sformatf("w%0d.busy", width_of(d)), 32'(o_busy[d]), 32'(m_busy[d]));
        cmp($sformatf("w%0d.done", width_of(d)), 32'(o_done[d]), 32'(m_done[d]));
        cmp($sformatf("w%0d.hi", width_of(d)), o_hi[d], m_hi[d]);
        cmp($sformatf("w%0d.lo", width_of(d)), o_lo[d], m_lo[d]);
      end
    end
  end

  task automatic issue(input int d, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    start_v[d] = 1'b1;
    op_v[d]    = op;
    a_v[d]     = a;
    b_v[d]     = b;
    @(negedge clk);
    start_v[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = 0;
    while (o_done[d] !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (o_done[d] !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL w%0d.done_timeout: got no done after %0d cycles", width_of(d), lat);
    end
  endtask

  task automatic check_lit(input string name, input int d, input logic [31:0] eh, input logic [31:0] el);
    cmp({name, ".hi"}, o_hi[d], eh);
    cmp({name, ".lo"}, o_lo[d], el);
    cmp({name, ".model_hi"}, m_hi[d], eh);
    cmp({name, ".model_lo"}, m_lo[d], el);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n_done;
    logic [5:0]  ops [4];
    logic [31:0] ra, rb;
    ops[0] = OP_MULT;
    ops[1] = OP_MULTU;
    ops[2] = OP_DIV;
    ops[3] = OP_DIVU;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0;
      op_v[d]    = '0;
      a_v[d]     = '0;
      b_v[d]     = '0;
    end
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    check_en = 1'b1;
    check_lit("reset32", 0, 32'h0, 32'h0);
    cmp("reset32.busy", 32'(o_busy[0]), 32'h0);
    cmp("reset8.busy", 32'(o_busy[1]), 32'h0);

    // Signed multiply with latency pinned
    issue(0, OP_MULT, 32'hFFFF_FFFD, 32'd5);
    cmp("mult.busy_after_accept", 32'(o_busy[0]), 32'h1);
    wait_done(0, lat);
    cmp("mult.latency", 32'(lat), 32'd33);
    check_lit("mult_m3x5", 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    @(negedge clk);
    cmp("mult.done_one_cycle", 32'(o_done[0]), 32'h0);

    issue(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, lat);
    check_lit("multu_max", 0, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(0, OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, lat);
    check_lit("div_m7_2", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(0, OP_DIVU, 32'd7, 32'd0);
    wait_done(0, lat);
    check_lit("divu_by0", 0, 32'h0000_0007, 32'hFFFF_FFFF);
    issue(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, lat);
    check_lit("div_ovf", 0, 32'h0000_0000, 32'h8000_0000);

    // MTHI while idle, then MTLO during an in-flight MULTU
    repeat (2) @(negedge clk);
    issue(0, OP_MTHI, 32'h1234_5678, 32'h0);
    cmp("mthi.hi", o_hi[0], 32'h1234_5678);
    cmp("mthi.busy", 32'(o_busy[0]), 32'h0);
    issue(0, OP_MULTU, 32'h0001_0000, 32'h0003_0000);
    repeat (5) @(negedge clk);
    issue(0, OP_MTLO, 32'hDEAD_BEEF, 32'h0);
    wait_done(0, lat);
    check_lit("mtlo_ignored", 0, 32'h0000_0003, 32'h0000_0000);

    // Back-to-back issue on the done cycle
    repeat (2) @(negedge clk);
    issue(0, OP_DIVU, 32'd100, 32'd7);
    wait_done(0, lat);
    check_lit("divu_100_7", 0, 32'd2, 32'd14);
    issue(0, OP_MULT, 32'd2, 32'd3);
    wait_done(0, lat);
    cmp("b2b.latency", 32'(lat), 32'd33);
    check_lit("b2b_mult", 0, 32'd0, 32'd6);

    // Reset mid-CALC discards the operation
    issue(0, OP_MULT, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_lit("midreset", 0, 32'h0, 32'h0);
    cmp("midreset.busy", 32'(o_busy[0]), 32'h0);
    cmp("midreset.done", 32'(o_done[0]), 32'h0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done[0] === 1'b1) n_done++;
    end
    cmp("midreset.no_late_done", 32'(n_done), 32'd0);
    issue(0, OP_MULT, 32'd7, 32'd6);
    wait_done(0, lat);
    check_lit("after_reset", 0, 32'd0, 32'd42);

    // WIDTH=8 directed boundaries
    issue(1, OP_DIV, 32'h80, 32'hFF);
    wait_done(1, lat);
    cmp("w8.latency", 32'(lat), 32'd9);
    check_lit("w8_div_ovf", 1, 32'h00, 32'h80);
    issue(1, OP_DIV, 32'hF9, 32'h00);
    wait_done(1, lat);
    check_lit("w8_div_by0", 1, 32'hF9, 32'hFF);
    issue(1, OP_MULT, 32'hFD, 32'h05);
    wait_done(1, lat);
    check_lit("w8_mult", 1, 32'hFF, 32'hF1);
    issue(1, OP_DIV, 32'hF9, 32'h02);
    wait_done(1, lat);
    check_lit("w8_div", 1, 32'hFF, 32'hFD);

    // WIDTH=8 random operands, zero divisors included, issued back-to-back
    for (int i = 0; i < 60; i++) begin
      ra = $urandom_range(0, 255);
      rb = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom_range(0, 255);
      issue(1, ops[$urandom_range(0, 3)], ra, rb);
      wait_done(1, lat);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
